// File: rtl/sequence_generator_shiftreg.sv
// Serial pattern generator: sends a captured pattern MSB first,
// repeated with optional idle gaps between frames.
module sequence_generator_shiftreg #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_pattern,
  input  logic [CNT_W-1:0] i_repeat,
  input  logic [CNT_W-1:0] i_gap,
  output logic             o_data,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_start_drop
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP,
    DONE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_dn;
  logic [WIDTH-1:0] pat;
  logic [CNT_W-1:0] frames;
  logic [CNT_W-1:0] gap_len;
  logic [CNT_W-1:0] gap_cnt;

  assign idx_dn = idx - 1'b1;

  // Outputs are loaded with the values of the state being entered,
  // so they line up with the registered state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= IDLE;
      idx          <= '0;
      pat          <= '0;
      frames       <= '0;
      gap_len      <= '0;
      gap_cnt      <= '0;
      o_data       <= 1'b0;
      o_valid      <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_start_drop <= 1'b0;
    end else begin
      o_start_drop <= i_start && (state != IDLE);
      o_done       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_start && !i_abort) begin
            state   <= SHIFT;
            pat     <= i_pattern;
            frames  <= i_repeat;
            gap_len <= i_gap;
            gap_cnt <= '0;
            idx     <= LAST;
            o_data  <= i_pattern[WIDTH-1];
            o_valid <= 1'b1;
            o_busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (i_abort) begin
            state   <= IDLE;
            o_data  <= 1'b0;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
          end else if (idx != '0) begin
            idx    <= idx_dn;
            o_data <= pat[idx_dn];
          end else if (frames == '0) begin
            state   <= DONE;
            o_done  <= 1'b1;
            o_data  <= 1'b0;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
          end else begin
            frames <= frames - ONE;
            if (gap_len != '0) begin
              state   <= GAP;
              gap_cnt <= gap_len;
              o_data  <= 1'b0;
              o_valid <= 1'b0;
            end else begin
              idx    <= LAST;
              o_data <= pat[WIDTH-1];
            end
          end
        end
        GAP: begin
          if (i_abort) begin
            state   <= IDLE;
            gap_cnt <= '0;
            o_data  <= 1'b0;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
          end else if (gap_cnt == ONE) begin
            state   <= SHIFT;
            gap_cnt <= '0;
            idx     <= LAST;
            o_data  <= pat[WIDTH-1];
            o_valid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - ONE;
          end
        end
        DONE: begin
          state   <= IDLE;
          o_data  <= 1'b0;
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          o_data  <= 1'b0;
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sequence_generator_shiftreg.md
SEQUENCE_GENERATOR_SHIFTREG -- requirements
Module: sequence_generator_shiftreg

Interface
REQ-001 SHALL have parameter WIDTH, default 6: pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter CNT_W, default 4: width of the repeat and gap fields.
REQ-003 SHALL have port i_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port i_start, input, 1: request to begin a transmission.
REQ-006 SHALL have port i_abort, input, 1: terminate the current transmission.
REQ-007 SHALL have port i_pattern, input, WIDTH: pattern to send, MSB first.
REQ-008 SHALL have port i_repeat, input, CNT_W: number of extra frames (total frames = i_repeat+1).
REQ-009 SHALL have port i_gap, input, CNT_W: idle cycles between frames.
REQ-010 SHALL have port o_data, output, 1: serial bit.
REQ-011 SHALL have port o_valid, output, 1: o_data carries a pattern bit this cycle.
REQ-012 SHALL have port o_busy, output, 1: transmission in progress.
REQ-013 SHALL have port o_done, output, 1: one-cycle pulse after the last bit of the last frame.
REQ-014 SHALL have port o_start_drop, output, 1: one-cycle pulse when i_start is ignored.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, GAP and DONE; all outputs SHALL be registered.
REQ-016 In IDLE with i_start=1, SHALL capture i_pattern, i_repeat and i_gap into internal registers and enter SHIFT with bit index WIDTH-1.
REQ-017 In SHIFT, SHALL drive o_valid=1 and o_data=captured_pattern[index]; the first bit appears the cycle after the start is accepted.
REQ-018 SHALL decrement the bit index each SHIFT cycle; when index=0, the frame ends.
REQ-019 At frame end, if frames remain and gap>0, SHALL enter GAP; if frames remain and gap=0, SHALL stay in SHIFT with index reloaded to WIDTH-1 (back-to-back, no bubble); if no frames remain, SHALL enter DONE.
REQ-020 In GAP, SHALL drive o_valid=0 and o_data=0 for exactly captured gap cycles, then enter SHIFT with index WIDTH-1.
REQ-021 The remaining-frame counter SHALL be CNT_W bits, loaded with i_repeat and decremented at each frame end; it SHALL NOT wrap below 0.
REQ-022 o_busy SHALL be 1 in SHIFT and GAP and 0 in IDLE and DONE.
REQ-023 DONE SHALL last one cycle with o_done=1, o_valid=0 and o_data=0, then return to IDLE.
REQ-024 An i_start in SHIFT, GAP or DONE SHALL be ignored and SHALL pulse o_start_drop for one cycle, starting the cycle after; captured values SHALL be unaffected.
REQ-025 i_abort=1 in SHIFT or GAP SHALL force IDLE on the next cycle with o_valid=0, o_busy=0 and no o_done pulse.
REQ-026 i_abort has priority over i_start in the same cycle; i_abort in IDLE or DONE SHALL have no effect except preventing a start.
REQ-027 In IDLE, o_data, o_valid, o_busy and o_done SHALL be 0.
REQ-028 The output stream SHALL be bit-compatible with the team's shift-register sequence detector, which samples o_data every clock.

Reset
REQ-029 i_reset=1 SHALL, at the next rising edge, force IDLE, clear all counters and captured registers, and drive all outputs to 0.
REQ-030 i_reset SHALL override i_start and i_abort.
REQ-031 Reset mid-transmission SHALL produce no o_done pulse.

Verification
REQ-032 Cycle-0 start with pattern=101001, repeat=0, gap=0 -> cycles 1-6: o_valid=1 and o_data=1,0,1,0,0,1; cycle 7: o_done=1, o_busy=0; cycle 8: IDLE.
REQ-033 Start with repeat=1, gap=2 -> bits in cycles 1-6, o_valid=0 in cycles 7-8, bits in cycles 9-14, o_done in cycle 15.
REQ-034 i_start at cycle 3 of a frame -> o_start_drop=1 at cycle 4; the bit stream is unchanged.
REQ-035 i_abort at cycle 3 -> cycle 4: o_valid=0 and o_busy=0; no o_done; a new start at cycle 5 is accepted.
REQ-036 i_reset at cycle 4 with simultaneous i_start -> cycle 5: all outputs 0 and state IDLE.
REQ-037 Loopback into the detector (pattern 101001), pattern=101001, repeat=2, gap=0 -> o_pattern_found=1 exactly in cycles 7, 13 and 19.
